// File: rtl/prom_loader.sv
// prom_loader: framed byte-stream loader for the Mico8 instruction RAM.
// Frame: SYNC, CNT_H, CNT_L, N x {B0, B1, B2}, [CKSUM].
// Holds the CPU in reset while loading and releases it after a good load.
// Optional feature macro: PROM_LOADER_CKSUM_EN adds the trailing checksum byte and check.
module prom_loader #(
  parameter int unsigned ADDR_W    = 9,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_ad,
  output logic [17:0]       wr_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned    TmoW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = (TIMEOUT > 0) ? TmoW'(TIMEOUT - 1) : '0;
  localparam int unsigned    MaxWords = 1 << ADDR_W;

  typedef enum logic [3:0] {
    StIdle,
    StCntH,
    StCntL,
    StB0,
    StB1,
    StB2,
    StWr,
`ifdef PROM_LOADER_CKSUM_EN
    StCksum,
`endif
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_h_q, cnt_h_d;
  logic [9:0]          n_q, n_d;
  logic [9:0]          wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          b0_q, b0_d;
  logic [7:0]          b1_q, b1_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_ad_q, wr_ad_d;
  logic [17:0]         wr_din_q, wr_din_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic                idle_like;
  logic                timed;
  logic [9:0]          n_new;
  logic                n_bad;
  logic [9:0]          wcnt_inc;

  assign in_ready = (state_q != StWr);
  assign accept   = in_valid && in_ready;
  assign wr_en    = wr_en_q;
  assign wr_ad    = wr_ad_q;
  assign wr_din   = wr_din_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

  assign idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
  // Timeout applies only while a frame is in progress and the loader is waiting for a byte.
  assign timed     = !idle_like && (state_q != StWr);
  assign n_new     = {cnt_h_q, in_data};
  assign n_bad     = (n_new == 10'd0) || (32'(n_new) > MaxWords);
  assign wcnt_inc  = wcnt_q + 10'd1;

`ifdef PROM_LOADER_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       cksum_ok;

  assign cksum_ok = ((sum_q + in_data) == 8'h00);

  // Checksum accumulator: cleared when a frame starts, sums every in-frame byte before CKSUM.
  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      if (idle_like) begin
        sum_d = 8'h00;
      end else if (state_q != StCksum) begin
        sum_d = sum_q + in_data;
      end
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  // Next-state and datapath: frame parsing, word assembly, write strobe and status flags.
  always_comb begin
    state_d    = state_q;
    cnt_h_d    = cnt_h_q;
    n_d        = n_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    wr_en_d    = 1'b0;
    wr_ad_d    = wr_ad_q;
    wr_din_d   = wr_din_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;
    tmo_d      = (accept || !timed) ? '0 : tmo_q + 1'b1;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d    = StCntH;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          addr_d     = '0;
          wcnt_d     = '0;
        end
      end
      StCntH: begin
        if (accept) begin
          cnt_h_d = in_data[1:0];
          state_d = StCntL;
        end
      end
      StCntL: begin
        if (accept) begin
          n_d = n_new;
          if (n_bad) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            state_d = StB0;
          end
        end
      end
      StB0: begin
        if (accept) begin
          b0_d    = in_data[1:0];
          state_d = StB1;
        end
      end
      StB1: begin
        if (accept) begin
          b1_d    = in_data;
          state_d = StB2;
        end
      end
      StB2: begin
        if (accept) begin
          wr_ad_d  = addr_q;
          wr_din_d = {b0_q, b1_q, in_data};
          wr_en_d  = 1'b1;
          state_d  = StWr;
        end
      end
      StWr: begin
        addr_d = addr_q + 1'b1;
        wcnt_d = wcnt_inc;
        if (wcnt_inc == n_q) begin
`ifdef PROM_LOADER_CKSUM_EN
          state_d    = StCksum;
`else
          state_d    = StDone;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
`endif
        end else begin
          state_d = StB0;
        end
      end
`ifdef PROM_LOADER_CKSUM_EN
      StCksum: begin
        if (accept) begin
          if (cksum_ok) begin
            state_d    = StDone;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Silence on the link mid-frame aborts the load; cpu_hold stays asserted.
    if ((TIMEOUT > 0) && timed && !accept && (tmo_q == TmoLast)) begin
      state_d = StErr;
      err_d   = 1'b1;
      wr_en_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_h_q    <= '0;
      n_q        <= '0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_ad_q    <= '0;
      wr_din_q   <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_h_q    <= cnt_h_d;
      n_q        <= n_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      tmo_q      <= tmo_d;
      wr_en_q    <= wr_en_d;
      wr_ad_q    <= wr_ad_d;
      wr_din_q   <= wr_din_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_prom_loader.sv
// Directed self-checking bench for prom_loader (TIMEOUT = 50).
// Works with or without PROM_LOADER_CKSUM_EN defined.
module tb_prom_loader;

  localparam int unsigned AW = 9;
`ifdef PROM_LOADER_CKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_ad;
  logic [17:0]   wr_din;
  logic          cpu_hold;
  logic          done;
  logic          err;

  prom_loader #(
    .ADDR_W   (AW),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (50)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_ad   (wr_ad),
    .wr_din  (wr_din),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log and ready bookkeeping, sampled on the falling edge.
  int            wcnt    = 0;
  int            nrdy    = 0;
  int            bad_rdy = 0;
  logic [AW-1:0] log_ad  [1024];
  logic [17:0]   log_din [1024];

  always @(negedge clk) begin
    if (wr_en) begin
      if (wcnt < 1024) begin
        log_ad[wcnt]  = wr_ad;
        log_din[wcnt] = wr_din;
      end
      wcnt++;
    end
    if (!in_ready) begin
      nrdy++;
      if (!wr_en) bad_rdy++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte and return just after the handshake edge; in_valid stays high.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("handshake_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Two-word frame: words 0x23456 and 0x1ABCD; good checksum is 0xF9.
  task automatic send_small(input logic [7:0] ck);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    if (CkEn) send_byte(ck);
  endtask

  int         base;
  int         rbase;
  int         bbase;
  int         bad_words;
  logic [7:0] s;
  logic [7:0] bb0, bb1, bb2;

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_ad", 32'(wr_ad), 32'd0);
    check("rst_wr_din", 32'(wr_din), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Noise before SYNC is discarded
    send_byte(8'h11);
    send_byte(8'h22);
    idle(3);
    check("noise_hold", 32'(cpu_hold), 32'd0);
    check("noise_done", 32'(done), 32'd0);

    // Good two-word load with in_valid held high throughout
    base  = wcnt;
    rbase = nrdy;
    bbase = bad_rdy;
    send_byte(8'hA5);
    #1;
    check("sync_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    if (CkEn) send_byte(8'hF9);
    idle(3);
    check("good_nwr", 32'(wcnt - base), 32'd2);
    check("good_ad0", 32'(log_ad[base]), 32'd0);
    check("good_din0", 32'(log_din[base]), 32'h23456);
    check("good_ad1", 32'(log_ad[base+1]), 32'd1);
    check("good_din1", 32'(log_din[base+1]), 32'h1ABCD);
    check("good_done", 32'(done), 32'd1);
    check("good_hold", 32'(cpu_hold), 32'd0);
    check("good_err", 32'(err), 32'd0);
    check("good_notready_cycles", 32'(nrdy - rbase), 32'd2);
    check("good_notready_outside_wr", 32'(bad_rdy - bbase), 32'd0);

`ifdef PROM_LOADER_CKSUM_EN
    // Bad checksum: writes still happen, load fails, CPU stays held
    base = wcnt;
    send_small(8'hFA);
    idle(3);
    check("badck_nwr", 32'(wcnt - base), 32'd2);
    check("badck_err", 32'(err), 32'd1);
    check("badck_done", 32'(done), 32'd0);
    check("badck_hold", 32'(cpu_hold), 32'd1);
    send_small(8'hF9);
    idle(3);
    check("reload_done", 32'(done), 32'd1);
    check("reload_hold", 32'(cpu_hold), 32'd0);
    check("reload_err", 32'(err), 32'd0);
`endif

    // N = 0 rejected right after CNT_L
    base = wcnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(1);
    check("n0_err", 32'(err), 32'd1);
    check("n0_hold", 32'(cpu_hold), 32'd1);
    check("n0_done", 32'(done), 32'd0);
    idle(3);
    check("n0_nwr", 32'(wcnt - base), 32'd0);

    // N = 513 rejected (CNT_H upper bits ignored: 0xFE -> 2)
    send_byte(8'hA5);
    send_byte(8'hFE);
    send_byte(8'h01);
    idle(3);
    check("n513_err", 32'(err), 32'd1);
    check("n513_nwr", 32'(wcnt - base), 32'd0);

    // N = 512, full depth; B0 upper bits carry junk that must be ignored
    base = wcnt;
    s    = 8'h02;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 512; i++) begin
      bb0 = 8'(i >> 7) | 8'hF0;
      bb1 = 8'(i);
      bb2 = 8'(i * 3);
      s   = s + bb0 + bb1 + bb2;
      send_byte(bb0);
      send_byte(bb1);
      send_byte(bb2);
    end
    if (CkEn) send_byte(8'(8'h00 - s));
    idle(3);
    check("full_nwr", 32'(wcnt - base), 32'd512);
    bad_words = 0;
    for (int i = 0; i < 512; i++) begin
      if (log_ad[base+i] !== AW'(i)) bad_words++;
      if (log_din[base+i] !== {2'(i >> 7), 8'(i), 8'(i * 3)}) bad_words++;
    end
    check("full_words_wrong", 32'(bad_words), 32'd0);
    check("full_done", 32'(done), 32'd1);
    check("full_hold", 32'(cpu_hold), 32'd0);

    // Timeout: err exactly 50 cycles after the last accepted byte
    base = wcnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (49) @(negedge clk);
    check("tmo_err_early", 32'(err), 32'd0);
    @(negedge clk);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_nwr", 32'(wcnt - base), 32'd0);

    // Asynchronous reset mid-frame, after the B1 byte
    base = wcnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h34);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_hold", 32'(cpu_hold), 32'd0);
    check("arst_wr_ad", 32'(wr_ad), 32'd0);
    check("arst_wr_din", 32'(wr_din), 32'd0);
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("arst_nwr", 32'(wcnt - base), 32'd0);
    send_small(8'hF9);
    idle(3);
    check("post_rst_nwr", 32'(wcnt - base), 32'd2);
    check("post_rst_din1", 32'(log_din[base+1]), 32'h1ABCD);
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_hold", 32'(cpu_hold), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
